// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-path widths, encodings and the IF queue entry layout.
package if_fetch_queue_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;
  localparam logic [INST_W-1:0]      NOP_INST  = '0;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } ifq_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// ifq_fifo: power-of-two circular queue with synchronous clear; an empty queue
// passes a same-cycle push straight through to a same-cycle pop.
module ifq_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = o_empty ? i_wdata : r_mem[r_rptr];
  assign w_do_push = i_push & (~o_full  | i_pop);
  assign w_do_pop  = i_pop  & (~o_empty | i_push);

  // Storage needs no reset; validity is carried by the count.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupled instruction fetch queue between the PC stage and IF/ID.
// Optional IFQ_BYPASS_EN lets a response land in IF/ID directly when the queue is empty.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [INST_ADDR_W-1:0] pc_in,
  input  logic                   pc_ce,
  input  logic                   flush,
  input  logic [5:0]             stall,
  output logic                   imem_req,
  output logic [INST_ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0]      imem_rdata,
  input  logic                   imem_valid,
  output logic                   fetch_stall,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  // Repeated flushes against a slow memory can stack several windows of doomed responses.
  localparam int unsigned DSC_W = CNT_W + 2;
  localparam int unsigned ENT_W = $bits(ifq_entry_t);

  logic [CNT_W-1:0]       r_outstanding;
  logic [DSC_W-1:0]       r_discard;
  logic [INST_ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0]      r_id_inst;
  logic                   r_id_valid;

  logic [CNT_W-1:0]       w_count;
  logic [CNT_W-1:0]       w_tag_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_tag_full;
  logic                   w_tag_empty;
  logic [INST_ADDR_W-1:0] w_tag;
  ifq_entry_t             w_head;
  ifq_entry_t             w_resp_entry;
  logic                   w_resp_live;
  logic                   w_push;
  logic                   w_pop;
  logic [DSC_W-1:0]       w_pending;
  logic                   w_unused;

  assign imem_req    = clr & pc_ce & ~flush &
                       ((SUM_W'(w_count) + SUM_W'(r_outstanding)) < SUM_W'(DEPTH));
  assign imem_addr   = pc_in;
  assign fetch_stall = pc_ce & ~imem_req;

  assign w_resp_live  = imem_valid & ~flush & (r_discard == '0);
  assign w_resp_entry = '{pc: w_tag, inst: imem_rdata};
  assign w_push       = w_resp_live;
`ifdef IFQ_BYPASS_EN
  // Empty queue falls through, so the response reaches IF/ID on its arrival edge.
  assign w_pop = ~flush & ~stall[1] & (~w_empty | w_push);
`else
  assign w_pop = ~flush & ~stall[1] & ~w_empty;
`endif

  assign w_pending = DSC_W'(r_outstanding) + r_discard;
  assign w_unused  = ^{stall[5:2], stall[0], w_full, w_tag_full, w_tag_empty, w_tag_count};

  ifq_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_entry_fifo (
    .clk     (clk),
    .rst_n   (clr),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_resp_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  ifq_fifo #(.DEPTH(DEPTH), .WIDTH(INST_ADDR_W)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (clr),
    .i_clr   (flush),
    .i_push  (imem_req),
    .i_pop   (w_resp_live),
    .i_wdata (pc_in),
    .o_rdata (w_tag),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  // Live-request and doomed-response accounting; a flush turns every pending response into a discard.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (flush) begin
      r_outstanding <= '0;
      r_discard     <= w_pending - DSC_W'(imem_valid && (w_pending != '0));
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(imem_req) - CNT_W'(w_resp_live);
      if (imem_valid && (r_discard != '0)) begin
        r_discard <= r_discard - DSC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_id_pc    <= ZERO_WORD;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (flush) begin
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (!stall[1]) begin
      if (w_pop) begin
        r_id_pc    <= w_head.pc;
        r_id_inst  <= w_head.inst;
        r_id_valid <= 1'b1;
      end else begin
        r_id_pc    <= ZERO_WORD;
        r_id_inst  <= NOP_INST;
        r_id_valid <= 1'b0;
      end
    end
  end

  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;
  assign id_valid = r_id_valid;

endmodule
